// File: rtl/timer_pkg.sv
// Shared constants for the countdown interval timer: state encoding and default widths.
package timer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int TIMER_RES    = 64;
   localparam int EXPIRY_CNT_W = 16;

endpackage

// File: rtl/countdown_timer_if.sv
// Load channel of the countdown timer: the tick count, its mode bit and the valid/ready pair.
interface countdown_timer_if
   import timer_pkg::*;
#(
   parameter int RESOLUTION = TIMER_RES
);

   // Handshake: a load transfers on a rising edge where load_valid && load_ready.
   // The master holds load_value/periodic stable while load_valid is high; load_ready
   // is combinational from timer state and abort, never from load_valid.
   logic [RESOLUTION-1:0] load_value;
   logic                  load_valid;
   logic                  load_ready;
   logic                  periodic;

   modport master (
      output load_value,
      output load_valid,
      output periodic,
      input  load_ready
   );

   modport slave (
      input  load_value,
      input  load_valid,
      input  periodic,
      output load_ready
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting interval timer with one-shot/periodic modes, pause gate,
// abort, and a saturating tally of expiries.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int RESOLUTION   = TIMER_RES,
   parameter int EXPIRY_CNT_W = timer_pkg::EXPIRY_CNT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   countdown_timer_if.slave        load_if,
   input  logic                    enable,
   input  logic                    abort,
   output logic [RESOLUTION-1:0]   counter_out,
   output logic                    busy,
   output logic                    expired,
   output logic [EXPIRY_CNT_W-1:0] expiry_count,
   output logic [0:0]              fsm_state
);

   localparam logic [RESOLUTION-1:0] CNT_ONE = {{(RESOLUTION-1){1'b0}}, 1'b1};

   logic [0:0]            state;
   logic                  mode_reg;
   logic [RESOLUTION-1:0] reload_reg;
   logic                  load_fire;
   logic                  load_zero;
   logic                  run_expire;
   logic [RESOLUTION-1:0] next_reload;

   // Loads are refused while aborting and during one-shot runs.
   assign load_if.load_ready = !abort && ((state == ST_IDLE) || ((state == ST_RUN) && mode_reg));
   assign load_fire  = load_if.load_valid && load_if.load_ready;
   assign load_zero  = (state == ST_IDLE) && load_fire && (load_if.load_value == '0);
   assign run_expire = (state == ST_RUN) && !abort && enable && (counter_out == CNT_ONE);

   // A load landing on the expiry edge replaces the reload for that very period.
   assign next_reload = load_fire ? load_if.load_value : reload_reg;

   assign busy      = (state == ST_RUN);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         counter_out <= '0;
         reload_reg  <= '0;
         mode_reg    <= 1'b0;
         expired     <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (abort) begin
            if (state == ST_RUN) begin
               counter_out <= '0;
               state       <= ST_IDLE;
            end
         end else if (state == ST_IDLE) begin
            if (load_zero) begin
               expired <= 1'b1;
            end else if (load_fire) begin
               counter_out <= load_if.load_value;
               reload_reg  <= load_if.load_value;
               mode_reg    <= load_if.periodic;
               state       <= ST_RUN;
            end
         end else begin
            if (load_fire) begin
               reload_reg <= load_if.load_value;
            end
            if (run_expire) begin
               expired <= 1'b1;
               if (mode_reg && (next_reload != '0)) begin
                  counter_out <= next_reload;
               end else begin
                  counter_out <= '0;
                  state       <= ST_IDLE;
               end
            end else if (enable) begin
               counter_out <= counter_out - CNT_ONE;
            end
         end
      end
   end

   sat_counter #(
      .WIDTH (EXPIRY_CNT_W)
   ) u_expiry_tally (
      .clk   (clk),
      .clear (reset),
      .inc   (run_expire || load_zero),
      .count (expiry_count)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed checking of countdown_timer against a tick-level behavioural model.
module tb_countdown_timer;

   localparam int RES = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic           abort;
   logic [RES-1:0] counter_out;
   logic           busy;
   logic           expired;
   logic [15:0]    expiry_count;
   logic [0:0]     fsm_state;
   logic [RES-1:0] s_counter_out;
   logic           s_busy;
   logic           s_expired;
   logic [1:0]     s_expiry_count;
   logic [0:0]     s_fsm_state;

   countdown_timer_if #(.RESOLUTION(RES)) bus ();
   countdown_timer_if #(.RESOLUTION(RES)) sbus ();

   countdown_timer #(.RESOLUTION(RES), .EXPIRY_CNT_W(16)) dut (
      .clk (clk), .reset (reset), .load_if (bus), .enable (enable), .abort (abort),
      .counter_out (counter_out), .busy (busy), .expired (expired),
      .expiry_count (expiry_count), .fsm_state (fsm_state)
   );

   countdown_timer #(.RESOLUTION(RES), .EXPIRY_CNT_W(2)) dut_small (
      .clk (clk), .reset (reset), .load_if (sbus), .enable (enable), .abort (abort),
      .counter_out (s_counter_out), .busy (s_busy), .expired (s_expired),
      .expiry_count (s_expiry_count), .fsm_state (s_fsm_state)
   );

   always #5 clk = ~clk;

   int n_vectors = 0;
   int n_errors  = 0;
   logic [RES-1:0] exp_q[$];

   // Reference model: "armed" flag, ticks remaining, value to re-arm with, mode, pulse, tally.
   bit             m_armed = 0;
   logic [RES-1:0] m_left = '0;
   logic [RES-1:0] m_rearm = '0;
   bit             m_repeat = 0;
   bit             m_pulse = 0;
   int             m_tally = 0;

   task automatic check(input string tag, input logic [RES-1:0] got, input logic [RES-1:0] want);
      n_vectors++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   function automatic bit m_ready(input bit ab);
      return !ab && (!m_armed || m_repeat);
   endfunction

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic m_expire();
      m_pulse = 1;
      m_tally++;
   endtask

   task automatic model_step(input bit rst, input logic [RES-1:0] lv, input bit lval,
                             input bit per, input bit en, input bit ab);
      bit take;
      take    = lval && m_ready(ab);
      m_pulse = 0;
      if (rst) begin
         m_armed = 0; m_left = '0; m_rearm = '0; m_repeat = 0; m_tally = 0;
      end else if (ab) begin
         m_armed = 0;
         m_left  = '0;
      end else if (!m_armed) begin
         if (take && lv == 0) m_expire();
         else if (take) begin
            m_armed = 1; m_left = lv; m_rearm = lv; m_repeat = per;
         end
      end else begin
         if (take) m_rearm = lv;
         if (en && m_left == 1) begin
            m_expire();
            if (m_repeat && m_rearm != 0) m_left = m_rearm;
            else begin
               m_left = '0; m_armed = 0;
            end
         end else if (en) begin
            m_left = m_left - 1;
         end
      end
   endtask

   task automatic cycle(input bit rst, input logic [RES-1:0] lv, input bit lval,
                        input bit per, input bit en, input bit ab);
      reset = rst; enable = en; abort = ab;
      bus.load_value = lv;  bus.load_valid = lval;  bus.periodic = per;
      sbus.load_value = lv; sbus.load_valid = lval; sbus.periodic = per;
      #1;
      if (!rst) begin
         check("load_ready", {63'd0, bus.load_ready}, {63'd0, m_ready(ab)});
         check("small_load_ready", {63'd0, sbus.load_ready}, {63'd0, m_ready(ab)});
      end
      model_step(rst, lv, lval, per, en, ab);
      exp_q.push_back(m_left);
      @(posedge clk);
      #1;
      check("counter_out", counter_out, exp_q.pop_front());
      check("small_counter_out", s_counter_out, m_left);
      check("busy", {63'd0, busy}, {63'd0, m_armed});
      check("fsm_state", {63'd0, fsm_state}, {63'd0, m_armed});
      check("expired", {63'd0, expired}, {63'd0, m_pulse});
      check("small_expired", {63'd0, s_expired}, {63'd0, m_pulse});
      check("expiry_count", {48'd0, expiry_count}, RES'(sat(m_tally, 65535)));
      check("small_expiry_count", {62'd0, s_expiry_count}, RES'(sat(m_tally, 3)));
   endtask

   task automatic idle(input int n, input bit en);
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, en, 0);
   endtask

   task automatic do_reset();
      cycle(1, '0, 0, 0, 0, 0);
      cycle(1, '0, 0, 0, 0, 0);
   endtask

   initial begin
      do_reset();
      check("reset_counter", counter_out, '0);
      check("reset_tally", {48'd0, expiry_count}, '0);

      // one-shot 5
      cycle(0, 64'd5, 1, 0, 1, 0);
      idle(7, 1);
      check("oneshot_tally", {48'd0, expiry_count}, 64'd1);

      // periodic 3 over 10 enabled cycles
      do_reset();
      cycle(0, 64'd3, 1, 1, 1, 0);
      idle(9, 1);
      check("periodic_tally", {48'd0, expiry_count}, 64'd3);
      cycle(0, '0, 0, 0, 1, 1);

      // periodic 4, retarget to 2 mid-period, then stop with 0
      do_reset();
      cycle(0, 64'd4, 1, 1, 1, 0);
      idle(1, 1);
      cycle(0, 64'd2, 1, 1, 1, 0);
      idle(7, 1);
      cycle(0, 64'd0, 1, 1, 1, 0);
      idle(4, 1);
      check("stop_busy", {63'd0, busy}, 64'd0);

      // pause at 4, then abort a second run at 2
      do_reset();
      cycle(0, 64'd6, 1, 0, 1, 0);
      idle(2, 1);
      idle(3, 0);
      idle(6, 1);
      cycle(0, 64'd5, 1, 0, 1, 0);
      idle(3, 1);
      cycle(0, 64'd9, 1, 0, 1, 1);
      idle(3, 1);
      check("abort_counter", counter_out, '0);

      // zero-length loads saturate the narrow tally
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 64'd0, 1, i[0], 1, 0);
         idle(1, 1);
      end
      check("sat_small_tally", {62'd0, s_expiry_count}, 64'd3);
      check("sat_wide_tally", {48'd0, expiry_count}, 64'd5);

      // reset while running
      cycle(0, 64'd8, 1, 1, 1, 0);
      idle(3, 1);
      do_reset();
      check("midrun_reset_counter", counter_out, '0);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         logic [RES-1:0] lv;
         lv = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : RES'($urandom_range(0, 6));
         cycle($urandom_range(0, 99) == 0, lv, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
               $urandom_range(0, 24) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
      $finish;
   end

endmodule
